// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and the handshake FSM state encoding for the
//               PS/2 Set-2 scan-code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;  // extended-key prefix
    localparam logic [7:0] SC_BRK = 8'hF0;  // break (key release) prefix

    // FIFO pop handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/scancode_to_ascii.sv
// ============================================================================
// Module      : scancode_to_ascii
// Description : Combinational Set-2 scan code to ASCII lookup. Covers the
//               letters a-z, digits 0-9, space and enter. Extended codes and
//               every other code map to 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scancode_to_ascii (
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    // ROM lookup; extended keys never carry a printable character
    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61; // a
                8'h32: ascii = 8'h62; // b
                8'h21: ascii = 8'h63; // c
                8'h23: ascii = 8'h64; // d
                8'h24: ascii = 8'h65; // e
                8'h2B: ascii = 8'h66; // f
                8'h34: ascii = 8'h67; // g
                8'h33: ascii = 8'h68; // h
                8'h43: ascii = 8'h69; // i
                8'h3B: ascii = 8'h6A; // j
                8'h42: ascii = 8'h6B; // k
                8'h4B: ascii = 8'h6C; // l
                8'h3A: ascii = 8'h6D; // m
                8'h31: ascii = 8'h6E; // n
                8'h44: ascii = 8'h6F; // o
                8'h4D: ascii = 8'h70; // p
                8'h15: ascii = 8'h71; // q
                8'h2D: ascii = 8'h72; // r
                8'h1B: ascii = 8'h73; // s
                8'h2C: ascii = 8'h74; // t
                8'h3C: ascii = 8'h75; // u
                8'h2A: ascii = 8'h76; // v
                8'h1D: ascii = 8'h77; // w
                8'h22: ascii = 8'h78; // x
                8'h35: ascii = 8'h79; // y
                8'h1A: ascii = 8'h7A; // z
                8'h45: ascii = 8'h30; // 0
                8'h16: ascii = 8'h31; // 1
                8'h1E: ascii = 8'h32; // 2
                8'h26: ascii = 8'h33; // 3
                8'h25: ascii = 8'h34; // 4
                8'h2E: ascii = 8'h35; // 5
                8'h36: ascii = 8'h36; // 6
                8'h3D: ascii = 8'h37; // 7
                8'h3E: ascii = 8'h38; // 8
                8'h46: ascii = 8'h39; // 9
                8'h29: ascii = 8'h20; // space
                8'h5A: ascii = 8'h0D; // enter
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule : scancode_to_ascii

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Pops bytes from the ps2_keyboard FIFO (ready / nextdata_n
//               handshake, one byte per 3 clocks), tracks the E0/F0 prefixes
//               and emits make/break key events with code, ASCII, held flag
//               and a wrapping press counter.
//               Optional build macro: TYPEMATIC_FILTER_EN - auto-repeat makes
//               of the held key still pulse ev_valid but are not counted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_down,
    output logic             ev_valid,
    output logic             ev_break,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_sticky
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_byte;
    logic             r_ext_f;
    logic             r_brk_f;

    logic             w_ndn_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_ext_nxt;
    logic             w_brk_nxt;
    logic [7:0]       w_code_nxt;
    logic             w_kext_nxt;
    logic [7:0]       w_ascii_nxt;
    logic             w_down_nxt;
    logic             w_ev_valid_nxt;
    logic             w_ev_break_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [7:0]       w_lookup;
    logic             w_match;
    logic             w_count_en;

    scancode_to_ascii u_rom (
        .code  (r_byte),
        .ext   (r_ext_f),
        .ascii (w_lookup)
    );

    // The latched byte names the same key as the last reported event
    assign w_match = (r_byte == key_code) && (r_ext_f == key_ext);

`ifdef TYPEMATIC_FILTER_EN
    // A make for the key already held is auto-repeat and is not counted
    assign w_count_en = !(key_down && w_match);
`else
    assign w_count_en = 1'b1;
`endif

    // Handshake state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pop strobe and byte interpretation
    always_comb begin
        w_state_nxt    = r_state;
        w_ndn_nxt      = 1'b1;
        w_byte_nxt     = r_byte;
        w_ext_nxt      = r_ext_f;
        w_brk_nxt      = r_brk_f;
        w_code_nxt     = key_code;
        w_kext_nxt     = key_ext;
        w_ascii_nxt    = key_ascii;
        w_down_nxt     = key_down;
        w_ev_valid_nxt = 1'b0;
        w_ev_break_nxt = ev_break;
        w_cnt_nxt      = press_count;
        case (r_state)
            ST_IDLE: begin
                if (kbd_ready) begin
                    w_byte_nxt  = kbd_data;
                    w_state_nxt = ST_POP;
                    w_ndn_nxt   = 1'b0;   // strobe is low for the whole POP cycle
                end
            end
            ST_POP: begin
                w_state_nxt = ST_WAIT;
                if (r_byte == SC_EXT) begin
                    w_ext_nxt = 1'b1;
                end else if (r_byte == SC_BRK) begin
                    w_brk_nxt = 1'b1;
                end else begin
                    w_ext_nxt      = 1'b0;
                    w_brk_nxt      = 1'b0;
                    w_ev_valid_nxt = 1'b1;
                    w_ev_break_nxt = r_brk_f;
                    w_code_nxt     = r_byte;
                    w_kext_nxt     = r_ext_f;
                    if (r_brk_f) begin
                        if (w_match) begin
                            w_down_nxt = 1'b0;
                        end
                    end else begin
                        w_down_nxt  = 1'b1;
                        w_ascii_nxt = w_lookup;
                        if (w_count_en) begin
                            w_cnt_nxt = press_count + CNT_W'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Let the FIFO's ready settle after the pop before re-sampling
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n  <= 1'b1;
            r_byte      <= 8'h00;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_ascii   <= 8'h00;
            key_down    <= 1'b0;
            ev_valid    <= 1'b0;
            ev_break    <= 1'b0;
            press_count <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            nextdata_n  <= w_ndn_nxt;
            r_byte      <= w_byte_nxt;
            r_ext_f     <= w_ext_nxt;
            r_brk_f     <= w_brk_nxt;
            key_code    <= w_code_nxt;
            key_ext     <= w_kext_nxt;
            key_ascii   <= w_ascii_nxt;
            key_down    <= w_down_nxt;
            ev_valid    <= w_ev_valid_nxt;
            ev_break    <= w_ev_break_nxt;
            press_count <= w_cnt_nxt;
            ovf_sticky  <= ovf_sticky | kbd_overflow;
        end
    end

endmodule : ps2_scancode_decoder

`default_nettype wire
